// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer burst writer.
// Holds the FSM state enum and the default bus widths.
package fb_pkg;

    localparam int FB_ADDR_W = 29;
    localparam int FB_DATA_W = 64;
    localparam int FB_BC_W   = 8;

    typedef enum logic [1:0] {
        FBW_IDLE,
        FBW_WAIT,
        FBW_BURST
    } fbw_state_t;

endpackage

// File: rtl/fb_sync_fifo.sv
// Show-ahead synchronous FIFO; rdata always shows the head entry.
// Ports: clk, rst_n, push/wdata, pop/rdata, count, full, empty.
module fb_sync_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_burst_writer.sv
// Avalon-MM burst write initiator: buffers span data, emits bursts <= MAX_BURST.
// Ports: cmd_* span command, in_* data stream, avm_* write master, busy/done.
// Optional macro FB_BURST_WRITER_STATS_EN adds stat_bursts / stat_stalls.
module fb_burst_writer
    import fb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int MAX_BURST  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [15:0]          cmd_words,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [DATA_W/8-1:0]  in_be,
    output logic [ADDR_W-1:0]    avm_address,
    output logic [FB_BC_W-1:0]   avm_burstcount,
    output logic [DATA_W-1:0]    avm_writedata,
    output logic [DATA_W/8-1:0]  avm_byteenable,
    output logic                 avm_write,
    input  logic                 avm_waitrequest,
    output logic                 busy,
    output logic                 done
`ifdef FB_BURST_WRITER_STATS_EN
    ,
    output logic [31:0]          stat_bursts,
    output logic [31:0]          stat_stalls
`endif
);

    localparam int BE_W = DATA_W / 8;
    localparam int FW   = DATA_W + BE_W;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0]        MAXB16 = 16'(MAX_BURST);
    localparam logic [FB_BC_W-1:0] MAXBC  = FB_BC_W'(MAX_BURST);

    fbw_state_t state_q;
    fbw_state_t state_d;

    logic [ADDR_W-1:0]  cur_addr_q;
    logic [15:0]        remaining_q;
    logic [FB_BC_W-1:0] beats_q;
    logic [FB_BC_W-1:0] len;
    logic [15:0]        rem_after;
    logic               cmd_fire;
    logic               can_start;
    logic               beat_acc;
    logic               last_beat;

    logic [FW-1:0]      fifo_rdata;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    assign in_ready = !fifo_full;

    fb_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .push  (in_valid && !fifo_full),
        .wdata ({in_be, in_data}),
        .pop   (beat_acc && !fifo_empty),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Remaining never exceeds MAX_BURST in the else branch, so the
    // low byte holds the full value there.
    assign len       = (remaining_q > MAXB16) ? MAXBC
                                              : remaining_q[FB_BC_W-1:0];
    assign can_start = 16'(fifo_count) >= 16'(len);
    assign cmd_fire  = cmd_valid && (state_q == FBW_IDLE);
    assign beat_acc  = (state_q == FBW_BURST) && !avm_waitrequest;
    assign last_beat = beat_acc && (beats_q == FB_BC_W'(1));
    assign rem_after = remaining_q - 16'(avm_burstcount);

    // Data lines are gated so they read zero outside a burst.
    assign avm_writedata  = avm_write ? fifo_rdata[DATA_W-1:0] : '0;
    assign avm_byteenable = avm_write ? fifo_rdata[FW-1:DATA_W] : '0;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= FBW_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        avm_write = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            FBW_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_fire && cmd_words != 16'd0) begin
                    state_d = FBW_WAIT;
                end
            end
            FBW_WAIT: begin
                if (can_start) begin
                    state_d = FBW_BURST;
                end
            end
            FBW_BURST: begin
                avm_write = 1'b1;
                if (last_beat) begin
                    state_d = (rem_after == 16'd0) ? FBW_IDLE : FBW_WAIT;
                end
            end
            default: begin
                state_d = FBW_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cur_addr_q     <= '0;
            remaining_q    <= '0;
            beats_q        <= '0;
            avm_address    <= '0;
            avm_burstcount <= '0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cmd_fire) begin
                cur_addr_q  <= cmd_addr;
                remaining_q <= cmd_words;
                if (cmd_words == 16'd0) begin
                    done <= 1'b1;
                end
            end
            if (state_q == FBW_WAIT && can_start) begin
                avm_address    <= cur_addr_q;
                avm_burstcount <= len;
                beats_q        <= len;
            end
            if (beat_acc) begin
                beats_q <= beats_q - 1'b1;
            end
            if (last_beat) begin
                cur_addr_q  <= cur_addr_q + ADDR_W'(avm_burstcount);
                remaining_q <= rem_after;
                if (rem_after == 16'd0) begin
                    done <= 1'b1;
                end
            end
        end
    end

`ifdef FB_BURST_WRITER_STATS_EN
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stat_bursts <= '0;
            stat_stalls <= '0;
        end else begin
            if (last_beat && stat_bursts != '1) begin
                stat_bursts <= stat_bursts + 1'b1;
            end
            if (avm_write && avm_waitrequest && stat_stalls != '1) begin
                stat_stalls <= stat_stalls + 1'b1;
            end
        end
    end
`endif

endmodule
